// File: rtl/key_event_pkg.sv
// Shared definitions for the key event block: channel FSM states, counter
// width and the default timing constants (100 MHz clock).
package key_event_pkg;

  // Channel FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    S_LOCK   = 2'd0,
    S_IDLE   = 2'd1,
    S_HELD   = 2'd2,
    S_REPEAT = 2'd3
  } state_t;

  // Width of the per-channel hold/repeat down-counter.
  localparam int CNT_W = 32;

  // Default timing: 1 s to long-press, 200 ms auto-repeat period at 100 MHz.
  localparam int unsigned DEF_LONG_CYCLES   = 32'd100_000_000;
  localparam int unsigned DEF_REPEAT_CYCLES = 32'd20_000_000;

endpackage

// File: rtl/key_event_ch.sv
// One key channel: turns a clean synchronous key level into registered
// one-cycle press / release / long-press / auto-repeat pulses plus a held level.
// 'release' is a reserved word in SystemVerilog, so the release pulse is named rel.
module key_event_ch
  import key_event_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rstn,
  input  logic key,
  output logic press,
  output logic rel,
  output logic longp,
  output logic rpt,
  output logic held
);

  // Counter reload values; the counter runs from value-1 down to 0 so that the
  // terminal event lands exactly value edges after the reload.
  localparam logic [CNT_W-1:0] LONG_LOAD = CNT_W'(LONG_CYCLES - 32'd1);
  localparam bit               RPT_EN    = (REPEAT_CYCLES != 32'd0);
  localparam logic [CNT_W-1:0] RPT_LOAD  = RPT_EN ? CNT_W'(REPEAT_CYCLES - 32'd1) : '0;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Channel FSM with counter and registered pulse/level outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_LOCK;
      cnt   <= '0;
      press <= 1'b0;
      rel   <= 1'b0;
      longp <= 1'b0;
      rpt   <= 1'b0;
      held  <= 1'b0;
    end else begin
      press <= 1'b0;
      rel   <= 1'b0;
      longp <= 1'b0;
      rpt   <= 1'b0;
      case (state)
        // A key already down at reset must be released before it can fire.
        S_LOCK: begin
          held <= 1'b0;
          if (!key) state <= S_IDLE;
        end
        S_IDLE: begin
          if (key) begin
            state <= S_HELD;
            press <= 1'b1;
            held  <= 1'b1;
            cnt   <= LONG_LOAD;
          end else begin
            held  <= 1'b0;
          end
        end
        // Release has priority over the long-press terminal count.
        S_HELD: begin
          if (!key) begin
            state <= S_IDLE;
            rel   <= 1'b1;
            held  <= 1'b0;
          end else if (cnt == '0) begin
            state <= S_REPEAT;
            longp <= 1'b1;
            held  <= 1'b1;
            cnt   <= RPT_LOAD;
          end else begin
            held  <= 1'b1;
            cnt   <= cnt - 1'b1;
          end
        end
        // With repeat disabled the channel simply sits here until release.
        S_REPEAT: begin
          if (!key) begin
            state <= S_IDLE;
            rel   <= 1'b1;
            held  <= 1'b0;
          end else if (RPT_EN && (cnt == '0)) begin
            rpt   <= 1'b1;
            held  <= 1'b1;
            cnt   <= RPT_LOAD;
          end else if (RPT_EN) begin
            held  <= 1'b1;
            cnt   <= cnt - 1'b1;
          end else begin
            held  <= 1'b1;
          end
        end
        default: begin
          state <= S_LOCK;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_event.sv
// N independent key channels plus a lowest-index priority encoder that
// summarises the press pulses as a single event valid/code pair.
module key_event
  import key_event_pkg::*;
#(
  parameter int          N             = 5,
  parameter int unsigned LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  localparam int         CODE_W        = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [N-1:0]      key,
  output logic [N-1:0]      press,
  output logic [N-1:0]      rel,
  output logic [N-1:0]      longp,
  output logic [N-1:0]      rpt,
  output logic [N-1:0]      held,
  output logic              evt_valid,
  output logic [CODE_W-1:0] evt_code
);

  for (genvar g = 0; g < N; g++) begin : g_ch
    key_event_ch #(
      .LONG_CYCLES   (LONG_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_ch (
      .clk   (clk),
      .rstn  (rstn),
      .key   (key[g]),
      .press (press[g]),
      .rel   (rel[g]),
      .longp (longp[g]),
      .rpt   (rpt[g]),
      .held  (held[g])
    );
  end

  assign evt_valid = |press;

  // Lowest-numbered pressed channel wins; scanning downward lets it overwrite.
  always_comb begin
    evt_code = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (press[i]) evt_code = CODE_W'(i);
    end
  end

endmodule

// File: tb/tb_key_event.sv
// Directed, table-driven bench for key_event (N=2, LONG=8, REPEAT=3) plus a
// second instance with auto-repeat disabled.
module tb_key_event;

  logic       clk = 1'b0;
  logic       rstn;
  logic [1:0] key;
  logic [1:0] press, rel, longp, rpt, held;
  logic       evt_valid;
  logic [0:0] evt_code;

  logic [1:0] key_nr;
  logic [1:0] press_nr, rel_nr, longp_nr, rpt_nr, held_nr;
  logic       evt_valid_nr;
  logic [0:0] evt_code_nr;

  always #5 clk = ~clk;

  key_event #(.N(2), .LONG_CYCLES(8), .REPEAT_CYCLES(3)) dut (
    .clk(clk), .rstn(rstn), .key(key), .press(press), .rel(rel),
    .longp(longp), .rpt(rpt), .held(held), .evt_valid(evt_valid), .evt_code(evt_code)
  );

  key_event #(.N(2), .LONG_CYCLES(8), .REPEAT_CYCLES(0)) dut_nr (
    .clk(clk), .rstn(rstn), .key(key_nr), .press(press_nr), .rel(rel_nr),
    .longp(longp_nr), .rpt(rpt_nr), .held(held_nr), .evt_valid(evt_valid_nr),
    .evt_code(evt_code_nr)
  );

  typedef struct {
    logic [1:0] key;
    logic [1:0] press;
    logic [1:0] rel;
    logic [1:0] longp;
    logic [1:0] rpt;
    logic [1:0] held;
    logic       ev;
    logic       code;
  } vec_t;

  vec_t tbl[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic void add(input logic [1:0] k, input logic [1:0] pr, input logic [1:0] rl,
                              input logic [1:0] lp, input logic [1:0] rp, input logic [1:0] hd,
                              input logic ev, input logic cd);
    vec_t v;
    v.key = k; v.press = pr; v.rel = rl; v.longp = lp; v.rpt = rp;
    v.held = hd; v.ev = ev; v.code = cd;
    tbl.push_back(v);
  endfunction

  function automatic logic [11:0] pack_main();
    return {press, rel, longp, rpt, held, evt_valid, evt_code};
  endfunction

  function automatic logic [11:0] pack_nr();
    return {press_nr, rel_nr, longp_nr, rpt_nr, held_nr, evt_valid_nr, evt_code_nr};
  endfunction

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got {press,rel,longp,rpt,held,vld,code}=%b, expected %b", name, act, exp);
    end
  endtask

  // Apply key values for the next rising edge, then sample 1 time unit after it.
  task automatic step(input logic [1:0] k, input logic [1:0] knr);
    @(negedge clk);
    key    = k;
    key_nr = knr;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Test 1 stimulus: key0 held through reset, then released and pressed.
    for (int i = 0; i < 20; i++) add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    // Test 3: press at edge k, held to k+19, low sampled at k+20.
    add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    for (int c = 1; c < 20; c++)
      add(2'b01, 2'b00, 2'b00, (c == 8) ? 2'b01 : 2'b00,
          (c == 11 || c == 14 || c == 17) ? 2'b01 : 2'b00, 2'b01, 1'b0, 1'b0);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    // Test 2: short press, key high for 5 edges.
    add(2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) add(2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0);
    add(2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    add(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    // Test 4: both keys on one edge, then staggered releases, then key1 alone.
    add(2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b11, 1'b1, 1'b0);
    add(2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 1'b0, 1'b0);
    add(2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 1'b0, 1'b0);
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    add(2'b10, 2'b10, 2'b00, 2'b00, 2'b00, 2'b10, 1'b1, 1'b1);
    add(2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);

    // Reset with key0 down.
    rstn   = 1'b0;
    key    = 2'b01;
    key_nr = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", pack_main(), 12'b0);
    chk("reset_state_nr", pack_nr(), 12'b0);
    @(negedge clk);
    rstn = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].key, 2'b00);
      chk($sformatf("vec%0d", i), pack_main(),
          {tbl[i].press, tbl[i].rel, tbl[i].longp, tbl[i].rpt, tbl[i].held, tbl[i].ev, tbl[i].code});
    end

    // Test 5: reset asserted in the 5th cycle of a hold.
    step(2'b01, 2'b00);
    chk("t5_press", pack_main(), {2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0});
    for (int c = 0; c < 4; c++) step(2'b01, 2'b00);
    chk("t5_held", pack_main(), {2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 1'b0, 1'b0});
    #2;
    rstn = 1'b0;
    #1;
    chk("t5_async_clear", pack_main(), 12'b0);
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(2'b01, 2'b00);
      chk($sformatf("t5_locked%0d", c), pack_main(), 12'b0);
    end
    step(2'b00, 2'b00);
    chk("t5_unlock", pack_main(), 12'b0);
    step(2'b01, 2'b00);
    chk("t5_repress", pack_main(), {2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 1'b1, 1'b0});
    step(2'b00, 2'b00);
    chk("t5_release", pack_main(), {2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});

    // Test 6: repeat disabled, key0 held 30 edges.
    for (int c = 0; c < 30; c++) begin
      step(2'b00, 2'b01);
      chk($sformatf("t6_hold%0d", c), pack_nr(),
          {(c == 0) ? 2'b01 : 2'b00, 2'b00, (c == 8) ? 2'b01 : 2'b00, 2'b00, 2'b01,
           (c == 0) ? 1'b1 : 1'b0, 1'b0});
    end
    step(2'b00, 2'b00);
    chk("t6_release", pack_nr(), {2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
